oflow_iou_match_sched: RTL and testbench

// - Initiator side of the oflow_calc_iou interface: holds up to HIST_DEPTH history bboxes and, per frame-k request,

---
 rtl/oflow_iou_match_sched.sv | 177 +++++++++++++++++
 tb/tb_oflow_iou_match_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_iou_match_sched.sv
// oflow_iou_match_sched: feeds (frame-k, history) bbox pairs into calc_iou one per cycle,
// tracks the best returned iou and reports index/score/threshold hit with a done pulse.
module oflow_iou_match_sched #(
  parameter int          HIST_DEPTH = 8,
  parameter int          IOU_LAT    = 1,
  parameter logic [21:0] IOU_THRESH = 22'd0,
  localparam int         IDX_W      = $clog2(HIST_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             hist_wr_en,
  input  logic [IDX_W-1:0] hist_wr_addr,
  input  logic [43:0]      hist_wr_data,
  input  logic             hist_clear,
  output logic             hist_wr_err,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [43:0]      req_bbox,
  output logic [43:0]      bbox_position_frame_k,
  output logic [43:0]      bbox_position_frame_history,
  output logic [10:0]      bbox_w_frame_k,
  output logic [10:0]      bbox_h_frame_k,
  output logic [10:0]      bbox_w_frame_history,
  output logic [10:0]      bbox_h_frame_history,
  input  logic [21:0]      iou_in,
  output logic             done,
  output logic [21:0]      best_iou,
  output logic [IDX_W-1:0] best_idx,
  output logic             match_found
);

  localparam int CNT_W = (IOU_LAT > 1) ? $clog2(IOU_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [IDX_W-1:0]            r_idx;
  logic [CNT_W-1:0]            r_drain_cnt;
  logic [43:0]                 r_hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0]       r_hval;
  logic [43:0]                 r_kbox;
  // Tag pipe: stage 0 travels with the registered bus, stage IOU_LAT lines up with iou_in.
  logic [IOU_LAT:0]            r_vld_pipe;
  logic [IOU_LAT:0][IDX_W-1:0] r_idx_pipe;
  logic [21:0]                 r_run_iou;
  logic [IDX_W-1:0]            r_run_idx;
  logic                        r_seen;

  logic             w_accept, w_last, w_idle, w_take, w_seen_nxt;
  logic [21:0]      w_best_iou;
  logic [IDX_W-1:0] w_best_idx;

  // Width/height with negative extents clamped to zero instead of wrapping.
  function automatic logic [10:0] dim(input logic [10:0] tl, input logic [10:0] br);
    return (br >= tl) ? (br - tl) : 11'd0;
  endfunction

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle;
  assign w_accept  = w_idle && req_valid;
  assign w_last    = (r_idx == IDX_W'(HIST_DEPTH - 1));

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_last) w_state_nxt = (IOU_LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (r_drain_cnt == CNT_W'(IOU_LAT - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, issue index and drain counter.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_idx <= '0;
      else if (r_state == S_ISSUE) r_idx <= r_idx + IDX_W'(1);
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + CNT_W'(1);
      else r_drain_cnt <= '0;
    end
  end

  // History valid bits: clear applies before write, so a same-cycle write survives.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_hval      <= '0;
      hist_wr_err <= 1'b0;
    end else begin
      hist_wr_err <= (hist_wr_en || hist_clear) && !w_idle;
      if (w_idle) begin
        if (hist_clear) r_hval <= '0;
        if (hist_wr_en) r_hval[hist_wr_addr] <= 1'b1;
      end
    end
  end

  // History payload needs no reset; the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (w_idle && hist_wr_en) r_hist[hist_wr_addr] <= hist_wr_data;
  end

  // Registered calc_iou bus plus the tag pipe; the bus holds its last pair outside ISSUE.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_kbox                      <= '0;
      bbox_position_frame_k       <= '0;
      bbox_position_frame_history <= '0;
      bbox_w_frame_k              <= '0;
      bbox_h_frame_k              <= '0;
      bbox_w_frame_history        <= '0;
      bbox_h_frame_history        <= '0;
      r_vld_pipe                  <= '0;
      r_idx_pipe                  <= '0;
    end else begin
      if (w_accept) r_kbox <= req_bbox;
      if (r_state == S_ISSUE) begin
        bbox_position_frame_k       <= r_kbox;
        bbox_position_frame_history <= r_hist[r_idx];
        bbox_w_frame_k              <= dim(r_kbox[43:33], r_kbox[21:11]);
        bbox_h_frame_k              <= dim(r_kbox[32:22], r_kbox[10:0]);
        bbox_w_frame_history        <= dim(r_hist[r_idx][43:33], r_hist[r_idx][21:11]);
        bbox_h_frame_history        <= dim(r_hist[r_idx][32:22], r_hist[r_idx][10:0]);
      end
      r_vld_pipe[0] <= (r_state == S_ISSUE) && r_hval[r_idx];
      r_idx_pipe[0] <= r_idx;
      for (int i = 1; i <= IOU_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_idx_pipe[i] <= r_idx_pipe[i-1];
      end
    end
  end

  // Best-match select: strictly greater wins, so ties keep the earlier (lower) index.
  always_comb begin
    w_take     = r_vld_pipe[IOU_LAT] && (!r_seen || (iou_in > r_run_iou));
    w_best_iou = w_take ? iou_in : r_run_iou;
    w_best_idx = w_take ? r_idx_pipe[IOU_LAT] : r_run_idx;
    w_seen_nxt = r_seen || r_vld_pipe[IOU_LAT];
  end

  // Running best and result registers; DONE folds in the final in-flight result.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_run_iou   <= '0;
      r_run_idx   <= '0;
      r_seen      <= 1'b0;
      done        <= 1'b0;
      best_iou    <= '0;
      best_idx    <= '0;
      match_found <= 1'b0;
    end else begin
      done <= (r_state == S_DONE);
      if (w_accept) begin
        r_run_iou <= '0;
        r_run_idx <= '0;
        r_seen    <= 1'b0;
      end else begin
        r_run_iou <= w_best_iou;
        r_run_idx <= w_best_idx;
        r_seen    <= w_seen_nxt;
      end
      if (r_state == S_DONE) begin
        best_iou    <= w_best_iou;
        best_idx    <= w_best_idx;
        match_found <= w_seen_nxt && (w_best_iou >= IOU_THRESH);
      end
    end
  end

endmodule

// File: tb/tb_oflow_iou_match_sched.sv
// Bench for oflow_iou_match_sched: directed vector table, hand-written corner sequences
// and randomized tables checked against a best-match reference model.
module tb_oflow_iou_match_sched;

  localparam int HD  = 8;
  localparam int LAT = 1;
  localparam int IW  = 3;

  logic          clk = 0;
  logic          reset_N = 0;
  logic          hist_wr_en = 0;
  logic [IW-1:0] hist_wr_addr = '0;
  logic [43:0]   hist_wr_data = '0;
  logic          hist_clear = 0;
  logic          hist_wr_err;
  logic          req_valid = 0;
  logic          req_ready;
  logic [43:0]   req_bbox = '0;
  logic [43:0]   bb_k, bb_h;
  logic [10:0]   w_k, h_k, w_h, h_h;
  logic [21:0]   iou_in = '0;
  logic          done;
  logic [21:0]   best_iou;
  logic [IW-1:0] best_idx;
  logic          match_found;

  oflow_iou_match_sched #(.HIST_DEPTH(HD), .IOU_LAT(LAT), .IOU_THRESH(22'd0)) dut (
    .clk(clk), .reset_N(reset_N),
    .hist_wr_en(hist_wr_en), .hist_wr_addr(hist_wr_addr), .hist_wr_data(hist_wr_data),
    .hist_clear(hist_clear), .hist_wr_err(hist_wr_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_bbox(req_bbox),
    .bbox_position_frame_k(bb_k), .bbox_position_frame_history(bb_h),
    .bbox_w_frame_k(w_k), .bbox_h_frame_k(h_k),
    .bbox_w_frame_history(w_h), .bbox_h_frame_history(h_h),
    .iou_in(iou_in), .done(done), .best_iou(best_iou), .best_idx(best_idx),
    .match_found(match_found)
  );

  always #5 clk = ~clk;

  // calc_iou stub: iou programmed per history bbox; unknown boxes return a huge value
  // so that an invalid entry leaking into the select is visible.
  logic [21:0] iou_map [logic [43:0]];
  always @(posedge clk) iou_in <= iou_map.exists(bb_h) ? iou_map[bb_h] : 22'h3FFFFF;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference table contents.
  logic [43:0] m_bb  [HD];
  bit          m_val [HD];

  // Captured at the first issued pair of the last request.
  logic [43:0] cap_bk, cap_bh;
  logic [10:0] cap_wk, cap_hk, cap_wh, cap_hh;

  typedef struct {
    logic [43:0] hb;
    logic [43:0] kb;
    logic [10:0] ewh, ehh, ewk, ehk;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [43:0] mk(input int xt, input int yt, input int xb, input int yb);
    return {11'(xt), 11'(yt), 11'(xb), 11'(yb)};
  endfunction

  // X_TL low bits carry the index so boxes at different entries never collide.
  function automatic logic [43:0] rbb(input int idx);
    return {8'($urandom), 3'(idx), 11'($urandom), 11'($urandom), 11'($urandom)};
  endfunction

  task automatic wr(input int addr, input logic [43:0] d, input bit clr);
    hist_wr_en = 1; hist_wr_addr = IW'(addr); hist_wr_data = d; hist_clear = clr;
    tick();
    hist_wr_en = 0; hist_clear = 0;
    if (clr) for (int i = 0; i < HD; i++) m_val[i] = 0;
    m_bb[addr] = d; m_val[addr] = 1;
  endtask

  task automatic clr();
    hist_clear = 1; tick(); hist_clear = 0;
    for (int i = 0; i < HD; i++) m_val[i] = 0;
  endtask

  // Reference: scan valid entries in index order, strict > keeps lowest index on ties.
  task automatic model(output logic [21:0] bi, output logic [IW-1:0] bx, output bit mf);
    bit seen = 0;
    bi = 0; bx = 0;
    for (int i = 0; i < HD; i++) begin
      if (m_val[i]) begin
        logic [21:0] v = iou_map.exists(m_bb[i]) ? iou_map[m_bb[i]] : 22'h3FFFFF;
        if (!seen || v > bi) begin bi = v; bx = IW'(i); seen = 1; end
      end
    end
    mf = seen;
  endtask

  // Issue a request; optionally inject a write+request at cycle inj (busy check).
  task automatic do_req(input logic [43:0] kb, input int inj, input logic [43:0] inj_bb);
    int lat = -1;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_bbox = kb;
    tick();
    req_valid = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin
        cap_bk = bb_k; cap_bh = bb_h; cap_wk = w_k; cap_hk = h_k; cap_wh = w_h; cap_hh = h_h;
      end
      if (inj != 0 && n == inj) begin
        hist_wr_en = 1; hist_wr_addr = 3'd6; hist_wr_data = inj_bb; req_valid = 1;
      end
      if (inj != 0 && n == inj + 1) begin
        hist_wr_en = 0; req_valid = 0;
        chk("busy_wr_err", hist_wr_err, 1);
        chk("busy_ready", req_ready, 0);
      end
      if (done) begin lat = n; break; end
    end
    chk("latency", 64'(lat), 64'(HD + LAT + 1));
  endtask

  task automatic check_result(input string tag);
    logic [21:0] ei; logic [IW-1:0] ex; bit em;
    model(ei, ex, em);
    chk({tag, "_best_iou"}, best_iou, ei);
    chk({tag, "_best_idx"}, best_idx, ex);
    chk({tag, "_match"}, match_found, em);
  endtask

  vec_t vt [3];

  initial begin
    vt[0] = '{mk(1000,1200,1010,1215), mk(500,250,520,280), 11'd10, 11'd15, 11'd20, 11'd30};
    vt[1] = '{mk(700,100,600,150),     mk(0,0,2047,2047),   11'd0,  11'd50, 11'd2047, 11'd2047};
    vt[2] = '{mk(5,5,5,4),             mk(300,400,300,401), 11'd0,  11'd0,  11'd0,  11'd1};
    for (int i = 0; i < HD; i++) begin m_val[i] = 0; m_bb[i] = '0; end

    // Reset state.
    repeat (3) tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_best_iou", best_iou, 0);
    chk("rst_match", match_found, 0);
    chk("rst_wr_err", hist_wr_err, 0);
    chk("rst_w_hist", w_h, 0);
    reset_N = 1;
    tick();

    // Vector table: clear+write same cycle, bus contents, w/h clamping, latency.
    for (int v = 0; v < 3; v++) begin
      iou_map[vt[v].hb] = 22'(77 + v);
      wr(0, vt[v].hb, 1'b1);
      do_req(vt[v].kb, 0, '0);
      check_result($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_bus_h", v), cap_bh, vt[v].hb);
      chk($sformatf("vec%0d_bus_k", v), cap_bk, vt[v].kb);
      chk($sformatf("vec%0d_wh", v), cap_wh, vt[v].ewh);
      chk($sformatf("vec%0d_hh", v), cap_hh, vt[v].ehh);
      chk($sformatf("vec%0d_wk", v), cap_wk, vt[v].ewk);
      chk($sformatf("vec%0d_hk", v), cap_hk, vt[v].ehk);
      tick();
      chk("done_pulse", done, 0);
    end

    // Tie: entries 1,3,5 with 100/400/400 -> index 3.
    clr();
    for (int i = 1; i <= 5; i += 2) m_bb[i] = rbb(i);
    iou_map[m_bb[1]] = 22'd100; iou_map[m_bb[3]] = 22'd400; iou_map[m_bb[5]] = 22'd400;
    wr(1, m_bb[1], 0); wr(3, m_bb[3], 0); wr(5, m_bb[5], 0);
    do_req(rbb(0), 0, '0);
    chk("tie_best_iou", best_iou, 22'd400);
    chk("tie_best_idx", best_idx, 3);
    chk("tie_match", match_found, 1);
    repeat (3) tick();
    chk("tie_hold", best_iou, 22'd400);

    // Busy: write + request mid-ISSUE are dropped; entry 6 would win if it landed.
    begin
      logic [43:0] bad = rbb(6);
      iou_map[bad] = 22'd999;
      do_req(rbb(0), 2, bad);
      check_result("busy");
      tick(); tick();
      chk("busy_no_accept", req_ready, 1);
      do_req(rbb(0), 0, '0);
      check_result("busy_again");
    end

    // Empty table.
    clr();
    do_req(rbb(0), 0, '0);
    chk("empty_best_iou", best_iou, 0);
    chk("empty_best_idx", best_idx, 0);
    chk("empty_match", match_found, 0);

    // Randomized tables.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) clr();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        int a = int'($urandom_range(0, HD - 1));
        logic [43:0] b = rbb(a);
        iou_map[b] = 22'($urandom_range(0, 3) * 100);
        wr(a, b, 1'b0);
      end
      do_req(rbb(0), 0, '0);
      check_result($sformatf("rnd%0d", it));
      tick();
    end

    // Reset mid-ISSUE: request aborted, table emptied.
    wr(2, rbb(2), 0);
    req_valid = 1; req_bbox = rbb(0);
    tick();
    req_valid = 0;
    tick(); tick();
    reset_N = 0;
    #1;
    chk("midrst_ready", req_ready, 1);
    tick();
    reset_N = 1;
    for (int i = 0; i < HD; i++) m_val[i] = 0;
    begin
      int seen_done = 0;
      for (int n = 0; n < 15; n++) begin
        if (done) seen_done++;
        tick();
      end
      chk("midrst_no_done", 64'(seen_done), 0);
    end
    do_req(rbb(0), 0, '0);
    chk("midrst_match", match_found, 0);
    chk("midrst_best_iou", best_iou, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
